// File: rtl/ecc_mem_responder_pkg.sv
// Shared types and constants for the ECC memory responder: FSM state
// encoding, fixed bank word width and the injection counter helper.
package ecc_mem_pkg;

    localparam int DATA_W    = 16;
    localparam int INJ_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RESP,
        INJ_RD,
        INJ_WR
    } state_t;

    // Increment that sticks at all-ones so the counter never wraps.
    function automatic logic [INJ_CNT_W-1:0] sat_inc(input logic [INJ_CNT_W-1:0] v);
        return (&v) ? v : v + INJ_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ecc_mem_responder_if.sv
// Host/injection bus between the ECC front end (master) and the memory
// responder (slave). Address width follows the responder's bank depth.
interface ecc_mem_responder_if
    import ecc_mem_pkg::*;
#(
    parameter int ADDR_W = 6
) ();

    logic [1:0]           chip_sel;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    wdata_up;
    logic [DATA_W-1:0]    wdata_down;
    logic [DATA_W-1:0]    rdata_up;
    logic [DATA_W-1:0]    rdata_down;
    logic                 rvalid;
    logic                 inj_req;
    logic [ADDR_W-1:0]    inj_addr;
    logic [DATA_W-1:0]    inj_mask_up;
    logic [DATA_W-1:0]    inj_mask_down;
    logic                 inj_done;
    logic [INJ_CNT_W-1:0] inj_count;

    modport master (
        output chip_sel, req_valid, req_we, req_addr, wdata_up, wdata_down,
               inj_req, inj_addr, inj_mask_up, inj_mask_down,
        input  req_ready, rdata_up, rdata_down, rvalid, inj_done, inj_count
    );

    modport slave (
        input  chip_sel, req_valid, req_we, req_addr, wdata_up, wdata_down,
               inj_req, inj_addr, inj_mask_up, inj_mask_down,
        output req_ready, rdata_up, rdata_down, rvalid, inj_done, inj_count
    );

endinterface

// File: rtl/ecc_mem_responder_mem_bank.sv
// Single-port synchronous RAM modelling one 16-bit memory chip. The read
// port is registered, so data for an address appears one edge later and
// a write returns the old word on the same edge.
module mem_bank #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write when enabled and always register the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ecc_mem_responder.sv
// Memory-side responder: two banks (up/down), host read/write arbitration
// and a read-modify-write fault-injection engine that XORs masks into a
// stored word pair. Every operation is serialised through one FSM.
module ecc_mem_responder
    import ecc_mem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input logic                clk,
    input logic                rst_n,
    ecc_mem_responder_if.slave bus
);

    state_t               state_q;
    state_t               state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    addr_d;
    logic [1:0]           sel_q;
    logic [1:0]           sel_d;
    logic [DATA_W-1:0]    mask_up_q;
    logic [DATA_W-1:0]    mask_up_d;
    logic [DATA_W-1:0]    mask_down_q;
    logic [DATA_W-1:0]    mask_down_d;

    logic                 rvalid_d;
    logic                 inj_done_d;
    logic [DATA_W-1:0]    rdata_up_d;
    logic [DATA_W-1:0]    rdata_down_d;
    logic [INJ_CNT_W-1:0] inj_count_d;

    logic [ADDR_W-1:0]    bank_addr;
    logic                 we_up;
    logic                 we_down;
    logic [DATA_W-1:0]    bank_wdata_up;
    logic [DATA_W-1:0]    bank_wdata_down;
    logic [DATA_W-1:0]    bank_rdata_up;
    logic [DATA_W-1:0]    bank_rdata_down;
    logic                 accept;

    assign bus.req_ready = (state_q == IDLE) && rst_n;
    assign accept        = bus.req_valid && bus.req_ready;

    // Next state, latched operands, bank controls and next output values.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        sel_d           = sel_q;
        mask_up_d       = mask_up_q;
        mask_down_d     = mask_down_q;
        rvalid_d        = 1'b0;
        inj_done_d      = 1'b0;
        rdata_up_d      = '0;
        rdata_down_d    = '0;
        inj_count_d     = bus.inj_count;
        bank_addr       = addr_q;
        we_up           = 1'b0;
        we_down         = 1'b0;
        bank_wdata_up   = bus.wdata_up;
        bank_wdata_down = bus.wdata_down;

        case (state_q)
            IDLE: begin
                bank_addr = bus.req_addr;
                if (accept) begin
                    if (bus.req_we) begin
                        we_up   = bus.chip_sel[1];
                        we_down = bus.chip_sel[0];
                    end else begin
                        addr_d  = bus.req_addr;
                        sel_d   = bus.chip_sel;
                        state_d = RD;
                    end
                end else if (bus.inj_req) begin
                    addr_d      = bus.inj_addr;
                    mask_up_d   = bus.inj_mask_up;
                    mask_down_d = bus.inj_mask_down;
                    state_d     = INJ_RD;
                end
            end
            RD: begin
                state_d = RESP;
            end
            RESP: begin
                rvalid_d     = 1'b1;
                rdata_up_d   = sel_q[1] ? bank_rdata_up   : '0;
                rdata_down_d = sel_q[0] ? bank_rdata_down : '0;
                state_d      = IDLE;
            end
            INJ_RD: begin
                state_d = INJ_WR;
            end
            INJ_WR: begin
                we_up           = 1'b1;
                we_down         = 1'b1;
                bank_wdata_up   = bank_rdata_up   ^ mask_up_q;
                bank_wdata_down = bank_rdata_down ^ mask_down_q;
                inj_done_d      = 1'b1;
                inj_count_d     = sat_inc(bus.inj_count);
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and visible outputs; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bus.rvalid     <= 1'b0;
            bus.inj_done   <= 1'b0;
            bus.rdata_up   <= '0;
            bus.rdata_down <= '0;
            bus.inj_count  <= '0;
        end else begin
            state_q        <= state_d;
            bus.rvalid     <= rvalid_d;
            bus.inj_done   <= inj_done_d;
            bus.rdata_up   <= rdata_up_d;
            bus.rdata_down <= rdata_down_d;
            bus.inj_count  <= inj_count_d;
        end
    end

    // Operand registers only matter once an operation is under way.
    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        sel_q       <= sel_d;
        mask_up_q   <= mask_up_d;
        mask_down_q <= mask_down_d;
    end

    mem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank_up (
        .clk   (clk),
        .we    (we_up && rst_n),
        .addr  (bank_addr),
        .wdata (bank_wdata_up),
        .rdata (bank_rdata_up)
    );

    mem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank_down (
        .clk   (clk),
        .we    (we_down && rst_n),
        .addr  (bank_addr),
        .wdata (bank_wdata_down),
        .rdata (bank_rdata_down)
    );

endmodule

// File: tb/tb_ecc_mem_responder.sv
// Self-checking bench for ecc_mem_responder: directed vector table,
// hand-written corner sequences and random traffic against a word-level
// memory model.
module tb_ecc_mem_responder;
    import ecc_mem_pkg::*;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ecc_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    ecc_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {OP_WR, OP_RD, OP_INJ} op_e;

    typedef struct {
        op_e         op;
        logic [1:0]  sel;
        logic [5:0]  addr;
        logic [15:0] d_up;
        logic [15:0] d_down;
        logic [15:0] exp_up;
        logic [15:0] exp_down;
        int          exp_cnt;
    } vec_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] model_up   [DEPTH];
    logic [15:0] model_down [DEPTH];
    int          model_cnt  = 0;
    vec_t        vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        bus.chip_sel      = 2'b00;
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_addr      = '0;
        bus.wdata_up      = '0;
        bus.wdata_down    = '0;
        bus.inj_req       = 1'b0;
        bus.inj_addr      = '0;
        bus.inj_mask_up   = '0;
        bus.inj_mask_down = '0;
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [5:0] addr,
                            input logic [15:0] up, input logic [15:0] down);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.chip_sel   = sel;
        bus.req_addr   = addr;
        bus.wdata_up   = up;
        bus.wdata_down = down;
        checkOutput("wr_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        if (sel[1]) model_up[addr]   = up;
        if (sel[0]) model_down[addr] = down;
    endtask

    task automatic do_read(input string name, input logic [1:0] sel, input logic [5:0] addr,
                           input logic [15:0] exp_up, input logic [15:0] exp_down);
        int lat;
        lat = 11;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.chip_sel  = sel;
        bus.req_addr  = addr;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.rvalid) begin
                lat = k;
                break;
            end
        end
        checkOutput({name, "_lat"}, 32'(lat), 32'd3);
        checkOutput({name, "_up"}, 32'(bus.rdata_up), 32'(exp_up));
        checkOutput({name, "_down"}, 32'(bus.rdata_down), 32'(exp_down));
        @(negedge clk);
        checkOutput({name, "_rvalid_low"}, 32'(bus.rvalid), 32'd0);
        checkOutput({name, "_rdata_zero"}, {bus.rdata_up, bus.rdata_down}, 32'd0);
    endtask

    task automatic do_inject(input string name, input logic [5:0] addr,
                             input logic [15:0] mu, input logic [15:0] md, input int exp_cnt);
        int lat;
        lat = 11;
        @(negedge clk);
        bus.inj_req       = 1'b1;
        bus.inj_addr      = addr;
        bus.inj_mask_up   = mu;
        bus.inj_mask_down = md;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.inj_done) begin
                lat = k;
                break;
            end
        end
        bus.inj_req = 1'b0;
        model_up[addr]   = model_up[addr] ^ mu;
        model_down[addr] = model_down[addr] ^ md;
        model_cnt        = (model_cnt < 255) ? model_cnt + 1 : 255;
        checkOutput({name, "_lat"}, 32'(lat), 32'd3);
        checkOutput({name, "_count"}, 32'(bus.inj_count), 32'(exp_cnt));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        model_cnt = 0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string name;
        name = $sformatf("vec%0d", idx);
        case (v.op)
            OP_WR:   do_write(v.sel, v.addr, v.d_up, v.d_down);
            OP_RD:   do_read(name, v.sel, v.addr, v.exp_up, v.exp_down);
            default: do_inject(name, v.addr, v.d_up, v.d_down, v.exp_cnt);
        endcase
    endtask

    initial begin
        int          rv_at;
        int          done_at;
        int          seen;
        logic [15:0] cap_up;
        logic [15:0] cap_down;
        logic [15:0] pre_up;
        logic [15:0] pre_down;

        vecs[0]  = '{OP_WR,  2'b11, 6'd5, 16'hA5A5, 16'h3C3C, 16'h0000, 16'h0000, 0};
        vecs[1]  = '{OP_RD,  2'b11, 6'd5, 16'h0000, 16'h0000, 16'hA5A5, 16'h3C3C, 0};
        vecs[2]  = '{OP_WR,  2'b11, 6'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0};
        vecs[3]  = '{OP_WR,  2'b10, 6'd7, 16'h1234, 16'h5555, 16'h0000, 16'h0000, 0};
        vecs[4]  = '{OP_RD,  2'b11, 6'd7, 16'h0000, 16'h0000, 16'h1234, 16'hFFFF, 0};
        vecs[5]  = '{OP_RD,  2'b01, 6'd7, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0};
        vecs[6]  = '{OP_WR,  2'b00, 6'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0};
        vecs[7]  = '{OP_RD,  2'b00, 6'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[8]  = '{OP_RD,  2'b11, 6'd5, 16'h0000, 16'h0000, 16'hA5A5, 16'h3C3C, 0};
        vecs[9]  = '{OP_INJ, 2'b00, 6'd5, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 1};
        vecs[10] = '{OP_RD,  2'b11, 6'd5, 16'h0000, 16'h0000, 16'hA5A4, 16'hBC3C, 0};
        vecs[11] = '{OP_INJ, 2'b00, 6'd9, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2};

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("rst_inj_done", 32'(bus.inj_done), 32'd0);
        checkOutput("rst_ready_low", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_rdata", {bus.rdata_up, bus.rdata_down}, 32'd0);
        checkOutput("rst_count", 32'(bus.inj_count), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);

        for (int a = 0; a < DEPTH; a++) begin
            do_write(2'b11, 6'(a), 16'($urandom), 16'($urandom));
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Host read and injection raised together: read first, then injection.
        pre_up   = model_up[5];
        pre_down = model_down[5];
        rv_at    = 0;
        done_at  = 0;
        cap_up   = '0;
        cap_down = '0;
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b0;
        bus.chip_sel      = 2'b11;
        bus.req_addr      = 6'd5;
        bus.inj_req       = 1'b1;
        bus.inj_addr      = 6'd5;
        bus.inj_mask_up   = 16'h00FF;
        bus.inj_mask_down = 16'hFF00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.rvalid && rv_at == 0) begin
                rv_at    = k;
                cap_up   = bus.rdata_up;
                cap_down = bus.rdata_down;
            end
            if (k == 4 || k == 5) checkOutput($sformatf("prio_ready_k%0d", k), 32'(bus.req_ready), 32'd0);
            if (bus.inj_done) begin
                done_at = k;
                break;
            end
        end
        bus.inj_req = 1'b0;
        model_up[5]   = model_up[5] ^ 16'h00FF;
        model_down[5] = model_down[5] ^ 16'hFF00;
        model_cnt     = model_cnt + 1;
        checkOutput("prio_rvalid_at", 32'(rv_at), 32'd3);
        checkOutput("prio_done_at", 32'(done_at), 32'd6);
        checkOutput("prio_rd_up", 32'(cap_up), 32'(pre_up));
        checkOutput("prio_rd_down", 32'(cap_down), 32'(pre_down));
        checkOutput("prio_count", 32'(bus.inj_count), 32'd3);
        do_read("prio_after", 2'b11, 6'd5, 16'hA55B, 16'h433C);

        // Reset while a read sits in RD: no response ever appears.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.chip_sel  = 2'b11;
        bus.req_addr  = 6'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        model_cnt = 0;
        #1;
        checkOutput("rstrd_rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("rstrd_rdata", {bus.rdata_up, bus.rdata_down}, 32'd0);
        checkOutput("rstrd_count", 32'(bus.inj_count), 32'd0);
        checkOutput("rstrd_ready", 32'(bus.req_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rvalid) seen = 1;
        end
        checkOutput("rstrd_no_rvalid", 32'(seen), 32'd0);

        // Reset while an injection sits in INJ_WR: word left untouched.
        do_inject("pre_abandon", 6'd12, 16'h0F0F, 16'h0000, 1);
        @(negedge clk);
        bus.inj_req       = 1'b1;
        bus.inj_addr      = 6'd12;
        bus.inj_mask_up   = 16'hFFFF;
        bus.inj_mask_down = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.inj_req = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        model_cnt = 0;
        #1;
        checkOutput("rstinj_done", 32'(bus.inj_done), 32'd0);
        checkOutput("rstinj_count", 32'(bus.inj_count), 32'd0);
        do_read("rstinj_word", 2'b11, 6'd12, model_up[12], model_down[12]);
        do_read("survive_a7", 2'b11, 6'd7, 16'h1234, 16'hFFFF);

        // Write presented while reset is held is not stored.
        @(negedge clk);
        rst_n          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.chip_sel   = 2'b11;
        bus.req_addr   = 6'd7;
        bus.wdata_up   = 16'h0000;
        bus.wdata_down = 16'h0000;
        #1;
        checkOutput("rstwr_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        rst_n         = 1'b1;
        model_cnt     = 0;
        do_read("rstwr_a7", 2'b11, 6'd7, 16'h1234, 16'hFFFF);

        // Random traffic against the word-level model.
        for (int i = 0; i < 150; i++) begin
            int          op;
            logic [1:0]  sel;
            logic [5:0]  addr;
            logic [15:0] du;
            logic [15:0] dd;
            op   = int'($urandom_range(0, 2));
            sel  = 2'($urandom_range(0, 3));
            addr = 6'($urandom_range(0, DEPTH - 1));
            du   = 16'($urandom);
            dd   = 16'($urandom);
            if (op == 0) begin
                do_write(sel, addr, du, dd);
            end else if (op == 1) begin
                do_read($sformatf("rnd%0d", i), sel, addr,
                        sel[1] ? model_up[addr] : 16'h0000,
                        sel[0] ? model_down[addr] : 16'h0000);
            end else begin
                do_inject($sformatf("rnd%0d", i), addr, du, dd,
                          (model_cnt < 255) ? model_cnt + 1 : 255);
            end
        end

        // Counter saturation after a clean reset.
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            do_inject("sat", 6'($urandom_range(0, DEPTH - 1)), 16'($urandom), 16'($urandom),
                      (model_cnt < 255) ? model_cnt + 1 : 255);
        end
        checkOutput("sat_256", 32'(bus.inj_count), 32'd255);
        do_inject("sat_257", 6'd3, 16'h0000, 16'h0000, 255);
        do_read("sat_word", 2'b11, 6'd3, model_up[3], model_down[3]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
